// File: rtl/bc1553_pkg.sv
// bc1553_pkg: shared constants for the 1553 bus-controller transmit path.
//   - message-table entry fields (18-bit entries: csw sync, dw sync, 16-bit word)
//   - seq_err codes reported by bc_msg_sequencer
//   - bc_msg_sequencer state encoding
package bc1553_pkg;

    // Entry layout: bit17 = command/status sync, bit16 = data sync, 15:0 = word.
    localparam int CSW_BIT  = 17;
    localparam int DW_BIT   = 16;
    localparam int WORD_MSB = 15;

    // seq_err codes (sticky until the next start).
    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_INVALID = 2'd1;
    localparam logic [1:0] ERR_TMO     = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;

    // Sequencer states.
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_GAP       = 3'd3;
    localparam logic [2:0] S_ISSUE     = 3'd4;
    localparam logic [2:0] S_WAIT_BUSY = 3'd5;
    localparam logic [2:0] S_WAIT_DONE = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

endpackage

// File: rtl/bc_msg_sequencer_if.sv
// bc_msg_sequencer_if: control, table and encoder signals of the sequencer.
//   master : the sequencer (drives tbl_addr, enc_*, seq_*, word_cnt)
//   slave  : host/table/encoder side (drives start, abort, list_base,
//            tbl_data, enc_busy)
interface bc_msg_sequencer_if #(
    parameter int ADDR_W = 9
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] list_base;
    logic [ADDR_W-1:0] tbl_addr;
    logic [17:0]       tbl_data;
    logic [15:0]       enc_dword;
    logic              enc_csw;
    logic              enc_dw;
    logic              enc_write;
    logic              enc_busy;
    logic              seq_busy;
    logic              seq_done;
    logic [1:0]        seq_err;
    logic [ADDR_W-1:0] word_cnt;

    modport master (
        input  start, abort, list_base, tbl_data, enc_busy,
        output tbl_addr, enc_dword, enc_csw, enc_dw, enc_write,
               seq_busy, seq_done, seq_err, word_cnt
    );

    modport slave (
        output start, abort, list_base, tbl_data, enc_busy,
        input  tbl_addr, enc_dword, enc_csw, enc_dw, enc_write,
               seq_busy, seq_done, seq_err, word_cnt
    );
endinterface

// File: rtl/bc_seq_timer.sv
// bc_seq_timer: loadable 8-bit down-counter with zero flag.
//   clk, rst : clock, async active-high reset
//   i_load   : load i_val this cycle (takes priority over counting)
//   i_val    : load value
//   o_zero   : count is zero; the counter stops there
module bc_seq_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_val,
    output logic       o_zero
);
    logic [7:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                r_cnt <= 8'd0;
        else if (i_load)        r_cnt <= i_val;
        else if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
    end

    assign o_zero = (r_cnt == 8'd0);
endmodule

// File: rtl/bc_msg_sequencer.sv
// bc_msg_sequencer: walks an 18-bit message list in a synchronous table and
// hands each word to the 1553 Manchester encoder.
//   clk, rst : encoder-domain clock, async active-high reset
//   bus      : bc_msg_sequencer_if.master (start/abort/list_base, table
//              port, encoder port, seq_busy/seq_done/seq_err/word_cnt)
// Optional feature macro: BC_SEQ_LOOP_EN -- the end marker restarts the list
// at list_base (with a gap) and pulses seq_done per pass; only abort stops it.
// GAP_CYCLES must be 1..255, BUSY_TMO 2..257 (both use the 8-bit timer).
module bc_msg_sequencer
    import bc1553_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int GAP_CYCLES = 16,
    parameter int BUSY_TMO   = 63
) (
    input  logic               clk,
    input  logic               rst,
    bc_msg_sequencer_if.master bus
);
    logic [2:0]        r_state, w_next;
    logic [ADDR_W-1:0] r_tbl_addr, r_word_cnt;
    logic              r_first, r_abort_pend;
    logic [15:0]       r_enc_dword;
    logic              r_enc_csw, r_enc_dw, r_enc_write, r_done;
    logic [1:0]        r_err, w_err_code;
    logic              w_err_set;
    logic [1:0]        w_sync;
    logic              w_tmr_load, w_tmr_zero;
    logic [7:0]        w_tmr_val;
`ifdef BC_SEQ_LOOP_EN
    logic [ADDR_W-1:0] r_base;
`endif

    assign w_sync = bus.tbl_data[CSW_BIT:DW_BIT];

    always_comb begin
        w_next     = r_state;
        w_err_set  = 1'b0;
        w_err_code = ERR_OK;
        case (r_state)
            S_IDLE, S_DONE: if (bus.start && !bus.abort) w_next = S_FETCH;
            S_FETCH: begin
                if (bus.abort) begin
                    w_next = S_DONE; w_err_set = 1'b1; w_err_code = ERR_ABORT;
                end else w_next = S_DECODE;
            end
            S_DECODE: begin
                if (bus.abort) begin
                    w_next = S_DONE; w_err_set = 1'b1; w_err_code = ERR_ABORT;
                end else begin
                    case (w_sync)
`ifdef BC_SEQ_LOOP_EN
                        2'b00: w_next = S_FETCH;
`else
                        2'b00: w_next = S_DONE;
`endif
                        2'b11: begin
                            w_next = S_DONE; w_err_set = 1'b1; w_err_code = ERR_INVALID;
                        end
                        2'b10:   w_next = r_first ? S_ISSUE : S_GAP;
                        default: w_next = S_ISSUE;
                    endcase
                end
            end
            S_GAP: begin
                if (bus.abort) begin
                    w_next = S_DONE; w_err_set = 1'b1; w_err_code = ERR_ABORT;
                end else if (w_tmr_zero) w_next = S_ISSUE;
            end
            S_ISSUE: w_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                // A busy already high (stale) simply exits on the first cycle.
                if (bus.enc_busy) w_next = S_WAIT_DONE;
                else if (w_tmr_zero) begin
                    w_next = S_DONE; w_err_set = 1'b1; w_err_code = ERR_TMO;
                end
            end
            S_WAIT_DONE: begin
                // An abort seen while the word is in flight lands here, so
                // the encoder always finishes the word.
                if (!bus.enc_busy) begin
                    if (r_abort_pend || bus.abort) begin
                        w_next = S_DONE; w_err_set = 1'b1; w_err_code = ERR_ABORT;
                    end else w_next = S_FETCH;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Timer reloads on entry: GAP holds GAP_CYCLES cycles; WAIT_BUSY times
    // out BUSY_TMO cycles after the strobe (ISSUE is the first of those).
    assign w_tmr_load = (w_next != r_state) &&
                        ((w_next == S_GAP) || (w_next == S_WAIT_BUSY));
    assign w_tmr_val  = (w_next == S_GAP) ? 8'(GAP_CYCLES - 1) : 8'(BUSY_TMO - 2);

    bc_seq_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_tmr_load),
        .i_val  (w_tmr_val),
        .o_zero (w_tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_tbl_addr   <= '0;
            r_word_cnt   <= '0;
            r_first      <= 1'b0;
            r_abort_pend <= 1'b0;
            r_enc_dword  <= 16'd0;
            r_enc_csw    <= 1'b0;
            r_enc_dw     <= 1'b0;
            r_enc_write  <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= ERR_OK;
`ifdef BC_SEQ_LOOP_EN
            r_base       <= '0;
`endif
        end else begin
            r_state     <= w_next;
            r_enc_write <= 1'b0;
            r_done      <= (w_next == S_DONE) && (r_state != S_DONE);
            if (w_err_set) r_err <= w_err_code;

            // Strobe and word latch on ISSUE entry, so enc_write is high
            // exactly during the ISSUE cycle.
            if ((w_next == S_ISSUE) && (r_state != S_ISSUE)) begin
                r_enc_dword <= bus.tbl_data[WORD_MSB:0];
                r_enc_csw   <= bus.tbl_data[CSW_BIT];
                r_enc_dw    <= bus.tbl_data[DW_BIT];
                r_enc_write <= 1'b1;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_next == S_FETCH) begin
                        r_tbl_addr   <= bus.list_base;
                        r_err        <= ERR_OK;
                        r_word_cnt   <= '0;
                        r_first      <= 1'b1;
                        r_abort_pend <= 1'b0;
`ifdef BC_SEQ_LOOP_EN
                        r_base       <= bus.list_base;
`endif
                    end
                end
`ifdef BC_SEQ_LOOP_EN
                S_DECODE: begin
                    if (w_next == S_FETCH) begin
                        r_tbl_addr <= r_base;
                        r_first    <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
`endif
                S_ISSUE: begin
                    r_word_cnt <= r_word_cnt + 1'b1;
                    r_tbl_addr <= r_tbl_addr + 1'b1;
                    r_first    <= 1'b0;
                    if (bus.abort) r_abort_pend <= 1'b1;
                end
                S_WAIT_BUSY, S_WAIT_DONE: if (bus.abort) r_abort_pend <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.tbl_addr  = r_tbl_addr;
    assign bus.enc_dword = r_enc_dword;
    assign bus.enc_csw   = r_enc_csw;
    assign bus.enc_dw    = r_enc_dw;
    assign bus.enc_write = r_enc_write;
    assign bus.seq_busy  = (r_state != S_IDLE) && (r_state != S_DONE);
    assign bus.seq_done  = r_done;
    assign bus.seq_err   = r_err;
    assign bus.word_cnt  = r_word_cnt;
endmodule

// File: tb/tb_bc_msg_sequencer.sv
// tb_bc_msg_sequencer: directed bench for bc_msg_sequencer with a table
// model (1-cycle read latency), an encoder busy model and a strobe
// scoreboard. Build with BC_SEQ_LOOP_EN to run the looping-list scenario.
module tb_bc_msg_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bc_msg_sequencer_if #(.ADDR_W(9)) bus ();

    bc_msg_sequencer #(.ADDR_W(9), .GAP_CYCLES(16), .BUSY_TMO(63)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wr_cnt = 0, done_cnt = 0, done_cyc = 0, done_idle = 0, start_cyc = 0;
    int wr_cyc[$];
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;
    logic [17:0] rom [0:511];
    int busy_len = 40;
    bit enc_dead = 1'b0;
    int busy_left;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Table: data valid one cycle after the address.
    always @(posedge clk) bus.tbl_data <= rom[bus.tbl_addr];

    // Encoder: busy for busy_len cycles starting the cycle after the strobe.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.enc_busy <= 1'b0; busy_left <= 0;
        end else if (bus.enc_write && !enc_dead) begin
            bus.enc_busy <= 1'b1; busy_left <= busy_len;
        end else if (busy_left > 1) busy_left <= busy_left - 1;
        else if (busy_left == 1) begin
            busy_left <= 0; bus.enc_busy <= 1'b0;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe scoreboard and done monitor, sampled just after the edge.
    always @(posedge clk) begin
        #1;
        if (bus.enc_write) begin
            wr_cnt++;
            wr_cyc.push_back(cyc);
            check("wr_expected_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("wr_word", {14'd0, bus.enc_dword, bus.enc_csw, bus.enc_dw}, mon_e);
            end
        end
        if (bus.seq_done) begin
            done_cnt++;
            done_cyc = cyc;
            if (!bus.seq_busy) done_idle++;
        end
    end

    task automatic push_exp(input logic [15:0] w, input logic csw, input logic dw);
        exp_q.push_back({14'd0, w, csw, dw});
    endtask

    task automatic clear();
        wr_cnt = 0; done_cnt = 0; done_idle = 0;
        wr_cyc.delete(); exp_q.delete();
    endtask

    task automatic do_start(input logic [8:0] base);
        bus.list_base = base; bus.start = 1'b1; start_cyc = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_wr(input int n, input int budget, input string tag);
        int k = 0;
        while (wr_cnt < n && k < budget) begin @(negedge clk); k++; end
        check(tag, 32'(wr_cnt >= n), 1);
    endtask

    task automatic wait_done(input int n, input int budget, input string tag);
        int k = 0;
        while (done_cnt < n && k < budget) begin @(negedge clk); k++; end
        check(tag, 32'(done_cnt >= n), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = 18'd0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.list_base = 9'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_tbl_addr", 32'(bus.tbl_addr), 0);
        check("rst_enc_write", 32'(bus.enc_write), 0);
        check("rst_seq_busy", 32'(bus.seq_busy), 0);
        check("rst_seq_done", 32'(bus.seq_done), 0);
        check("rst_seq_err", 32'(bus.seq_err), 0);
        check("rst_word_cnt", 32'(bus.word_cnt), 0);

`ifdef BC_SEQ_LOOP_EN
        // Looping list: done per pass, gap before each restart, abort ends it.
        clear(); busy_len = 10;
        rom[0] = 18'h20AAA; rom[1] = 18'h10BBB; rom[2] = 18'h00000;
        for (int p = 0; p < 3; p++) begin
            push_exp(16'h0AAA, 1'b1, 1'b0); push_exp(16'h0BBB, 1'b0, 1'b1);
        end
        do_start(9'd0);
        wait_done(3, 2000, "loop_three_passes");
        check("loop_busy_at_done", 32'(bus.seq_busy), 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        wait_done(4, 50, "loop_abort_done");
        @(negedge clk);
        check("loop_wr_cnt", 32'(wr_cnt), 6);
        check("loop_err", 32'(bus.seq_err), 3);
        check("loop_done_idle", 32'(done_idle), 1);
        check("loop_seq_busy", 32'(bus.seq_busy), 0);
        if (wr_cyc.size() >= 3) begin
            check("loop_first_lat", 32'(wr_cyc[0] - start_cyc), 3);
            check("loop_intra_gap", 32'(wr_cyc[1] - wr_cyc[0]), 14);
            check("loop_restart_gap", 32'(wr_cyc[2] - wr_cyc[1]), 32);
        end
`else
        // Basic run: three words, no gaps
        clear(); busy_len = 40;
        rom[0] = 18'h21234; rom[1] = 18'h1ABCD; rom[2] = 18'h15555; rom[3] = 18'h00000;
        push_exp(16'h1234, 1'b1, 1'b0); push_exp(16'hABCD, 1'b0, 1'b1);
        push_exp(16'h5555, 1'b0, 1'b1);
        do_start(9'd0);
        check("basic_seq_busy", 32'(bus.seq_busy), 1);
        wait_done(1, 1000, "basic_done_seen");
        check("basic_wr_cnt", 32'(wr_cnt), 3);
        if (wr_cyc.size() == 3) begin
            check("basic_start_lat", 32'(wr_cyc[0] - start_cyc), 3);
            check("basic_interval1", 32'(wr_cyc[1] - wr_cyc[0]), 44);
            check("basic_interval2", 32'(wr_cyc[2] - wr_cyc[1]), 44);
            check("basic_done_lat", 32'(done_cyc - wr_cyc[2]), 44);
        end
        check("basic_err", 32'(bus.seq_err), 0);
        check("basic_word_cnt", 32'(bus.word_cnt), 3);
        repeat (2) @(negedge clk);
        check("basic_done_once", 32'(done_cnt), 1);
        check("basic_done_pulse_low", 32'(bus.seq_done), 0);
        check("basic_idle", 32'(bus.seq_busy), 0);

        // Gap before a non-first command word
        clear(); busy_len = 20;
        rom[0] = 18'h20001; rom[1] = 18'h20002; rom[2] = 18'h00000;
        push_exp(16'h0001, 1'b1, 1'b0); push_exp(16'h0002, 1'b1, 1'b0);
        do_start(9'd0);
        wait_done(1, 1000, "gap_done_seen");
        check("gap_wr_cnt", 32'(wr_cnt), 2);
        if (wr_cyc.size() == 2)
            check("gap_interval", 32'(wr_cyc[1] - wr_cyc[0]), 20 + 4 + 16);
        check("gap_err", 32'(bus.seq_err), 0);

        // Invalid entry at address 1
        clear();
        rom[0] = 18'h20011; rom[1] = 18'h3FFFF;
        push_exp(16'h0011, 1'b1, 1'b0);
        do_start(9'd0);
        wait_done(1, 1000, "inv_done_seen");
        check("inv_err", 32'(bus.seq_err), 1);
        check("inv_wr_cnt", 32'(wr_cnt), 1);
        check("inv_word_cnt", 32'(bus.word_cnt), 1);

        // Busy timeout
        clear(); enc_dead = 1'b1;
        rom[0] = 18'h20022; rom[1] = 18'h00000;
        push_exp(16'h0022, 1'b1, 1'b0);
        do_start(9'd0);
        wait_done(1, 500, "tmo_done_seen");
        check("tmo_err", 32'(bus.seq_err), 2);
        if (wr_cyc.size() == 1)
            check("tmo_latency", 32'(done_cyc - wr_cyc[0]), 63);
        check("tmo_wr_cnt", 32'(wr_cnt), 1);
        enc_dead = 1'b0;
        @(negedge clk);

        // Abort during WAIT_DONE of word 2, then restart
        clear(); busy_len = 30;
        rom[0] = 18'h20100; rom[1] = 18'h10101; rom[2] = 18'h10102; rom[3] = 18'h00000;
        push_exp(16'h0100, 1'b1, 1'b0); push_exp(16'h0101, 1'b0, 1'b1);
        do_start(9'd0);
        wait_wr(2, 500, "abort_word2_seen");
        repeat (3) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        wait_done(1, 500, "abort_done_seen");
        check("abort_err", 32'(bus.seq_err), 3);
        check("abort_wr_cnt", 32'(wr_cnt), 2);
        check("abort_word_cnt", 32'(bus.word_cnt), 2);
        if (wr_cyc.size() == 2)
            check("abort_word_completes", 32'(done_cyc - wr_cyc[1]), 32);
        @(negedge clk);
        clear();
        push_exp(16'h0100, 1'b1, 1'b0); push_exp(16'h0101, 1'b0, 1'b1);
        push_exp(16'h0102, 1'b0, 1'b1);
        do_start(9'd0);
        check("restart_err_cleared", 32'(bus.seq_err), 0);
        check("restart_busy", 32'(bus.seq_busy), 1);
        wait_done(1, 1000, "restart_done_seen");
        check("restart_wr_cnt", 32'(wr_cnt), 3);
        check("restart_err", 32'(bus.seq_err), 0);

        // Address wrap 511 -> 0
        clear(); busy_len = 10;
        rom[511] = 18'h20511; rom[0] = 18'h10600; rom[1] = 18'h00000;
        push_exp(16'h0511, 1'b1, 1'b0); push_exp(16'h0600, 1'b0, 1'b1);
        do_start(9'd511);
        wait_wr(1, 100, "wrap_word1_seen");
        check("wrap_addr_before", 32'(bus.tbl_addr), 511);
        @(negedge clk);
        check("wrap_addr_after", 32'(bus.tbl_addr), 0);
        wait_done(1, 500, "wrap_done_seen");
        check("wrap_wr_cnt", 32'(wr_cnt), 2);
        check("wrap_word_cnt", 32'(bus.word_cnt), 2);
        check("wrap_addr_end", 32'(bus.tbl_addr), 1);
`endif

        // Reset asserted mid-WAIT_DONE
        clear(); busy_len = 40;
        rom[0] = 18'h21234; rom[1] = 18'h1ABCD; rom[2] = 18'h00000;
        push_exp(16'h1234, 1'b1, 1'b0);
        do_start(9'd0);
        wait_wr(1, 100, "rstmid_word1_seen");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid_tbl_addr", 32'(bus.tbl_addr), 0);
        check("rstmid_enc_write", 32'(bus.enc_write), 0);
        check("rstmid_enc_dword", 32'(bus.enc_dword), 0);
        check("rstmid_seq_busy", 32'(bus.seq_busy), 0);
        check("rstmid_word_cnt", 32'(bus.word_cnt), 0);
        check("rstmid_seq_err", 32'(bus.seq_err), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rstmid_stays_idle", 32'(bus.seq_busy), 0);
        check("rstmid_no_more_wr", 32'(wr_cnt), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
